// File: rtl/ov7670_fifo_frame_reader.sv
// ---------------------------------------------------------------------------
// ov7670_fifo_frame_reader
//   Snapshot/stream engine for an OV7670 camera behind an AL422B frame FIFO.
//   Resets the FIFO write pointer on a VSYNC rising edge, waits for one full
//   frame (VSYNC fall then the next VSYNC rise), resets the read pointer, then
//   drains the frame byte by byte through a valid/ready stream. Before the
//   pixel bytes, an optional 0xA5,0x5A sync header can be sent. The engine can
//   loop frames in continuous mode and can be aborted.
//
// Ports
//   i_clk          system clock
//   i_reset_p      synchronous active-high reset
//   i_start        capture request, acts on its rising edge while idle
//   i_cont_mode    sampled with i_start: 1 = loop frames until abort
//   i_abort        stop at the next safe point and return to idle
//   i_vsync        camera VSYNC (asynchronous, synchronised here)
//   i_fifo_d       AL422B read data
//   o_fifo_wrst    FIFO write-pointer reset, active low
//   o_fifo_rrst    FIFO read-pointer reset, active low
//   o_fifo_rclk    FIFO read clock
//   o_m_data       stream byte
//   o_m_valid      o_m_data valid
//   i_m_ready      sink accepts when o_m_valid & i_m_ready
//   o_m_last       high with the last pixel byte of a frame
//   o_busy         engine not idle
//   o_frame_done   one-clock pulse after the last byte is accepted
// ---------------------------------------------------------------------------
module ov7670_fifo_frame_reader #(
    parameter int IMG_W     = 160,
    parameter int IMG_H     = 120,
    parameter int BPP       = 2,
    parameter int RCLK_HALF = 2,
    parameter int WRST_CYC  = 4,
    parameter int HEADER_EN = 1
) (
    input  logic       i_clk,
    input  logic       i_reset_p,
    input  logic       i_start,
    input  logic       i_cont_mode,
    input  logic       i_abort,
    input  logic       i_vsync,
    input  logic [7:0] i_fifo_d,
    output logic       o_fifo_wrst,
    output logic       o_fifo_rrst,
    output logic       o_fifo_rclk,
    output logic [7:0] o_m_data,
    output logic       o_m_valid,
    input  logic       i_m_ready,
    output logic       o_m_last,
    output logic       o_busy,
    output logic       o_frame_done
);

    localparam int N_BYTES = IMG_W * IMG_H * BPP;
    localparam int CNT_W   = $clog2(N_BYTES + 1);
    localparam int TMR_MAX = (RCLK_HALF > WRST_CYC) ? RCLK_HALF : WRST_CYC;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] RH_LAST   = TMR_W'(RCLK_HALF - 1);
    localparam logic [TMR_W-1:0] WR_LAST   = TMR_W'(WRST_CYC - 1);
    localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(N_BYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARM,
        S_WRST,
        S_CAPTURE,
        S_RRST,
        S_HDR,
        S_RD_LO,
        S_RD_HI,
        S_PUSH
    } state_t;

    state_t             r_state;
    logic               r_vs_meta;
    logic               r_vs_sync;
    logic               r_vs_prev;
    logic               r_start_prev;
    logic               r_cont;
    logic               r_abort;
    logic               r_seen_fall;
    logic               r_pulse;
    logic               r_hdr_sel;
    logic [TMR_W-1:0]   r_tmr;
    logic [CNT_W-1:0]   r_cnt;

    logic w_vs_rise;
    logic w_vs_fall;
    logic w_start_rise;
    logic w_abort;
    logic w_hs;
    logic w_tmr_rh;

    assign w_vs_rise    = r_vs_sync & ~r_vs_prev;
    assign w_vs_fall    = ~r_vs_sync & r_vs_prev;
    assign w_start_rise = i_start & ~r_start_prev;
    // The live input joins the latched request so the states that honour an
    // abort immediately do not lose a clock.
    assign w_abort      = r_abort | i_abort;
    assign w_hs         = o_m_valid & i_m_ready;
    assign w_tmr_rh     = (r_tmr == RH_LAST);
    assign o_busy       = (r_state != S_IDLE);

    // NOTE: every register here is assigned with <= so all state updates see
    // the values from before the clock edge, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset_p) begin
            r_state      <= S_IDLE;
            r_vs_meta    <= 1'b0;
            r_vs_sync    <= 1'b0;
            r_vs_prev    <= 1'b0;
            r_start_prev <= 1'b0;
            r_cont       <= 1'b0;
            r_abort      <= 1'b0;
            r_seen_fall  <= 1'b0;
            r_pulse      <= 1'b0;
            r_hdr_sel    <= 1'b0;
            r_tmr        <= '0;
            r_cnt        <= '0;
            o_fifo_wrst  <= 1'b1;
            o_fifo_rrst  <= 1'b1;
            o_fifo_rclk  <= 1'b1;
            o_m_data     <= 8'h00;
            o_m_valid    <= 1'b0;
            o_m_last     <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            r_vs_meta    <= i_vsync;
            r_vs_sync    <= r_vs_meta;
            r_vs_prev    <= r_vs_sync;
            r_start_prev <= i_start;
            o_frame_done <= 1'b0;
            if (i_abort && (r_state != S_IDLE)) r_abort <= 1'b1;

            unique case (r_state)
                S_IDLE: begin
                    r_abort <= 1'b0;
                    if (w_start_rise) begin
                        r_cont  <= i_cont_mode;
                        r_state <= S_ARM;
                    end
                end

                S_ARM: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                    end else if (w_vs_rise) begin
                        o_fifo_wrst <= 1'b0;
                        r_tmr       <= '0;
                        r_state     <= S_WRST;
                    end
                end

                S_WRST: begin
                    if (w_abort) begin
                        o_fifo_wrst <= 1'b1;
                        r_state     <= S_IDLE;
                    end else if (r_tmr == WR_LAST) begin
                        o_fifo_wrst <= 1'b1;
                        r_seen_fall <= 1'b0;
                        r_state     <= S_CAPTURE;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end

                // The camera writes between VSYNC fall and the following rise.
                S_CAPTURE: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                    end else if (!r_seen_fall) begin
                        if (w_vs_fall) r_seen_fall <= 1'b1;
                    end else if (w_vs_rise) begin
                        o_fifo_rrst <= 1'b0;
                        o_fifo_rclk <= 1'b0;
                        r_tmr       <= '0;
                        r_pulse     <= 1'b0;
                        r_state     <= S_RRST;
                    end
                end

                // AL422B only resets its read pointer on rclk edges, so two
                // complete low/high rclk pulses are issued with rrst held low.
                S_RRST: begin
                    if (w_abort) begin
                        o_fifo_rrst <= 1'b1;
                        o_fifo_rclk <= 1'b1;
                        r_state     <= S_IDLE;
                    end else if (w_tmr_rh) begin
                        r_tmr <= '0;
                        if (!o_fifo_rclk) begin
                            o_fifo_rclk <= 1'b1;
                        end else if (!r_pulse) begin
                            r_pulse     <= 1'b1;
                            o_fifo_rclk <= 1'b0;
                        end else begin
                            o_fifo_rrst <= 1'b1;
                            r_cnt       <= '0;
                            if (HEADER_EN != 0) begin
                                o_m_data  <= 8'hA5;
                                o_m_valid <= 1'b1;
                                r_hdr_sel <= 1'b0;
                                r_state   <= S_HDR;
                            end else begin
                                o_fifo_rclk <= 1'b0;
                                r_state     <= S_RD_LO;
                            end
                        end
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end

                S_HDR: begin
                    if (w_hs) begin
                        if (w_abort) begin
                            o_m_valid <= 1'b0;
                            r_state   <= S_IDLE;
                        end else if (!r_hdr_sel) begin
                            o_m_data  <= 8'h5A;
                            r_hdr_sel <= 1'b1;
                        end else begin
                            o_m_valid   <= 1'b0;
                            o_fifo_rclk <= 1'b0;
                            r_tmr       <= '0;
                            r_state     <= S_RD_LO;
                        end
                    end
                end

                S_RD_LO: begin
                    if (w_tmr_rh) begin
                        o_fifo_rclk <= 1'b1;
                        r_tmr       <= '0;
                        r_state     <= S_RD_HI;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end

                // Data is captured only after rclk has been high long enough
                // for the FIFO output to settle.
                S_RD_HI: begin
                    if (w_tmr_rh) begin
                        o_m_data  <= i_fifo_d;
                        o_m_valid <= 1'b1;
                        o_m_last  <= (r_cnt == BYTE_LAST);
                        r_state   <= S_PUSH;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end

                // rclk stays high here, so a stalled sink never advances the FIFO.
                S_PUSH: begin
                    if (w_hs) begin
                        o_m_valid <= 1'b0;
                        o_m_last  <= 1'b0;
                        r_cnt     <= r_cnt + 1'b1;
                        if (w_abort) begin
                            r_state <= S_IDLE;
                        end else if (o_m_last) begin
                            o_frame_done <= 1'b1;
                            r_state      <= r_cont ? S_ARM : S_IDLE;
                        end else begin
                            o_fifo_rclk <= 1'b0;
                            r_tmr       <= '0;
                            r_state     <= S_RD_LO;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_fifo_frame_reader.sv
// ---------------------------------------------------------------------------
// tb_ov7670_fifo_frame_reader
//   Self-checking bench for ov7670_fifo_frame_reader. A small AL422B model
//   serves bytes {frame_id, index}; an expected-stream queue is filled per
//   written frame (header then pixel bytes) and every accepted byte is
//   compared against it. A second instance with RCLK_HALF=3 checks rclk
//   timing and the no-header path.
// ---------------------------------------------------------------------------
module tb_ov7670_fifo_frame_reader;

    localparam int N1 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_p = 1'b1;
    logic       start = 1'b0, cont_mode = 1'b0, abort = 1'b0, vsync = 1'b0;
    logic       m_ready = 1'b1;
    logic [7:0] fifo_d = 8'h00;
    logic       fifo_wrst, fifo_rrst, fifo_rclk, m_valid, m_last, busy, frame_done;
    logic [7:0] m_data;

    logic       start3 = 1'b0;
    logic [7:0] fifo_d3 = 8'h00;
    logic       wrst3, rrst3, rclk3, valid3, last3, busy3, done3;
    logic [7:0] data3;

    ov7670_fifo_frame_reader #(
        .IMG_W(4), .IMG_H(2), .BPP(2), .RCLK_HALF(2), .WRST_CYC(4), .HEADER_EN(1)
    ) u_dut (
        .i_clk(clk), .i_reset_p(reset_p), .i_start(start), .i_cont_mode(cont_mode),
        .i_abort(abort), .i_vsync(vsync), .i_fifo_d(fifo_d),
        .o_fifo_wrst(fifo_wrst), .o_fifo_rrst(fifo_rrst), .o_fifo_rclk(fifo_rclk),
        .o_m_data(m_data), .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_last(m_last),
        .o_busy(busy), .o_frame_done(frame_done)
    );

    ov7670_fifo_frame_reader #(
        .IMG_W(2), .IMG_H(1), .BPP(1), .RCLK_HALF(3), .WRST_CYC(2), .HEADER_EN(0)
    ) u_dut3 (
        .i_clk(clk), .i_reset_p(reset_p), .i_start(start3), .i_cont_mode(1'b0),
        .i_abort(1'b0), .i_vsync(vsync), .i_fifo_d(fifo_d3),
        .o_fifo_wrst(wrst3), .o_fifo_rrst(rrst3), .o_fifo_rclk(rclk3),
        .o_m_data(data3), .o_m_valid(valid3), .i_m_ready(1'b1), .o_m_last(last3),
        .o_busy(busy3), .o_frame_done(done3)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- FIFO / camera model and expected stream ----------------
    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t       q[$];
    logic [7:0] fid = 8'hFF;
    int         rd_ptr = 0;
    int         p3 = 0;

    // Each write-pointer reset marks a new frame written by the camera.
    always @(negedge fifo_wrst) begin
        fid = fid + 8'd1;
        q.push_back('{d: 8'hA5, l: 1'b0});
        q.push_back('{d: 8'h5A, l: 1'b0});
        for (int i = 0; i < N1; i++) q.push_back('{d: {fid[3:0], 4'(i)}, l: (i == N1 - 1)});
    end

    always @(posedge fifo_rclk) begin
        if (!fifo_rrst) rd_ptr = 0;
        else begin
            fifo_d = {fid[3:0], rd_ptr[3:0]};
            rd_ptr++;
        end
    end

    always @(posedge rclk3) begin
        if (!rrst3) p3 = 0;
        else begin
            fifo_d3 = 8'h30 + 8'(p3);
            p3++;
        end
    end

    // ---------------- monitors ----------------
    int         cyc = 0;
    int         hs_cnt = 0, last_cnt = 0, fd_cnt = 0, wrst_pulses = 0, wrst_low = 0, wrst_w = 0;
    int         rrst_falls = 0, rclk_rises = 0, low1 = 0, log_n = 0;
    logic [7:0] log_b[0:31];
    logic       pv = 1'b0, pr = 1'b0, pl = 1'b0, prev_last_hs = 1'b0;
    logic [7:0] pd = 8'h00;
    int         hs3 = 0, fd3 = 0, low3 = 0, n_r3 = 0;
    int         rise_t3[0:7];

    always @(posedge clk) cyc++;
    always @(negedge fifo_rrst) rrst_falls++;
    always @(posedge fifo_rclk) rclk_rises++;
    always @(posedge rclk3) begin
        if (n_r3 < 8) rise_t3[n_r3] = cyc;
        n_r3++;
    end

    always @(negedge clk) begin
        if (reset_p) begin
            pv = 1'b0; prev_last_hs = 1'b0; wrst_low = 0; low1 = 0; low3 = 0;
        end else begin
            if (pv && !pr) begin
                check("valid_held", m_valid, 1);
                check("data_stable", m_data, pd);
                check("last_stable", m_last, pl);
            end
            if (m_valid) check("rclk_high_while_valid", fifo_rclk, 1);
            if (frame_done) begin
                fd_cnt++;
                check("frame_done_after_last", prev_last_hs, 1);
            end
            prev_last_hs = 1'b0;
            if (m_valid && m_ready) begin
                hs_cnt++;
                if (log_n < 32) log_b[log_n] = m_data;
                log_n++;
                if (m_last) last_cnt++;
                check("byte_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    check("stream_data", m_data, e.d);
                    check("stream_last", m_last, e.l);
                end
                prev_last_hs = m_last;
            end
            pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;

            if (!fifo_wrst) wrst_low++;
            else if (wrst_low != 0) begin
                wrst_w = wrst_low; wrst_pulses++; wrst_low = 0;
            end
            if (!fifo_rclk) low1++;
            else if (low1 != 0) begin
                check("rclk_low_width", low1, 2); low1 = 0;
            end

            if (!rclk3) low3++;
            else if (low3 != 0) begin
                check("rclk3_low_width", low3, 3); low3 = 0;
            end
            if (valid3) begin
                check("dut3_data", data3, 8'h30 + 8'(hs3));
                check("dut3_last", last3, hs3 == 1);
                hs3++;
            end
            if (done3) fd3++;
        end
    end

    // ---------------- sink ready driver ----------------
    int rdy_mode = 0;  // 0: always ready, 1: ~30% ready, 2: stalled
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       m_ready = ($urandom_range(0, 99) < 30);
            2:       m_ready = 1'b0;
            default: m_ready = 1'b1;
        endcase
    end

    // ---------------- helpers ----------------
    // NOTE: stimulus is driven with blocking assignments 1 ns after the
    // rising edge, so the DUT always samples settled inputs.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic vs_pulse(input int hi, input int lo);
        vsync = 1'b1; tick(hi);
        vsync = 1'b0; tick(lo);
    endtask

    task automatic pulse_start(input logic cm);
        cont_mode = cm; start = 1'b1; tick(2);
        start = 1'b0; cont_mode = 1'b0; tick(1);
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        while (busy && n < max) begin tick(1); n++; end
        check(name, busy, 0);
    endtask

    task automatic wait_hs(input string name, input int target, input int max);
        int n = 0;
        while (hs_cnt < target && n < max) begin tick(1); n++; end
        check(name, hs_cnt >= target, 1);
    endtask

    task automatic clear_counts();
        hs_cnt = 0; last_cnt = 0; fd_cnt = 0; wrst_pulses = 0; wrst_w = 0;
        rrst_falls = 0; rclk_rises = 0; log_n = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wrst"}, fifo_wrst, 1);
        check({tag, "_rrst"}, fifo_rrst, 1);
        check({tag, "_rclk"}, fifo_rclk, 1);
        check({tag, "_valid"}, m_valid, 0);
        check({tag, "_last"}, m_last, 0);
        check({tag, "_data"}, m_data, 8'h00);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int hs_at;
        tick(3);
        reset_p = 1'b0;
        tick(1);
        check_reset_outputs("reset");
        check("reset_busy3", busy3, 0);

        // T1: one frame, full-speed sink.
        clear_counts();
        pulse_start(1'b0);
        check("t1_busy", busy, 1);
        vs_pulse(20, 100);
        check("t1_wrst_width", wrst_w, 4);
        check("t1_no_rrst_yet", rrst_falls, 0);
        check("t1_no_rclk_yet", rclk_rises, 0);
        vs_pulse(20, 300);
        wait_idle("t1_idle", 400);
        check("t1_bytes", hs_cnt, N1 + 2);
        check("t1_last_count", last_cnt, 1);
        check("t1_frame_done", fd_cnt, 1);
        check("t1_rclk_rises", rclk_rises, N1 + 2);
        check("t1_hdr0", log_b[0], 8'hA5);
        check("t1_hdr1", log_b[1], 8'h5A);
        check("t1_first_px", log_b[2], 8'h00);
        check("t1_last_px", log_b[17], 8'h0F);
        check("t1_queue_empty", q.size(), 0);
        check("t1_wrst_pulses", wrst_pulses, 1);

        // T2: start while VSYNC already high.
        clear_counts();
        vsync = 1'b1; tick(10);
        pulse_start(1'b0);
        tick(10);
        vsync = 1'b0; tick(50);
        check("t2_no_wrst", wrst_pulses + wrst_low, 0);
        check("t2_no_rrst_a", rrst_falls, 0);
        check("t2_no_rclk_a", rclk_rises, 0);
        vs_pulse(20, 50);
        check("t2_one_wrst", wrst_pulses, 1);
        check("t2_no_rrst_b", rrst_falls, 0);
        check("t2_no_rclk_b", rclk_rises, 0);
        vs_pulse(20, 300);
        wait_idle("t2_idle", 400);
        check("t2_rrst", rrst_falls, 1);
        check("t2_frame_done", fd_cnt, 1);
        check("t2_bytes", hs_cnt, N1 + 2);

        // T3: random back-pressure.
        clear_counts();
        rdy_mode = 1;
        pulse_start(1'b0);
        vs_pulse(20, 60);
        vs_pulse(20, 400);
        wait_idle("t3_idle", 2000);
        rdy_mode = 0;
        check("t3_bytes", hs_cnt, N1 + 2);
        check("t3_rclk_rises", rclk_rises, N1 + 2);
        check("t3_frame_done", fd_cnt, 1);
        check("t3_queue_empty", q.size(), 0);

        // T4a: continuous mode, three frames, then abort while armed.
        clear_counts();
        pulse_start(1'b1);
        repeat (6) vs_pulse(20, 250);
        check("t4_frame_done", fd_cnt, 3);
        check("t4_wrst_pulses", wrst_pulses, 3);
        check("t4_rrst_falls", rrst_falls, 3);
        check("t4_bytes", hs_cnt, 3 * (N1 + 2));
        check("t4_last_count", last_cnt, 3);
        check("t4_still_armed", busy, 1);
        abort = 1'b1; tick(1); abort = 1'b0;
        wait_idle("t4_abort_idle", 20);
        check("t4_no_extra_done", fd_cnt, 3);

        // T4b: abort in the middle of frame 2.
        clear_counts();
        q.delete();
        pulse_start(1'b1);
        vs_pulse(20, 250);
        vs_pulse(20, 250);
        vs_pulse(20, 50);
        vsync = 1'b1; tick(20); vsync = 1'b0;
        wait_hs("t4b_reach_mid", N1 + 2 + 6, 400);
        hs_at = hs_cnt;
        abort = 1'b1; tick(1); abort = 1'b0;
        wait_idle("t4b_abort_idle", 100);
        check("t4b_at_most_one_hs", (hs_cnt - hs_at) <= 1, 1);
        check("t4b_valid_low", m_valid, 0);
        check("t4b_frame_done", fd_cnt, 1);
        vs_pulse(20, 100);
        vs_pulse(20, 100);
        check("t4b_stay_idle", busy, 0);
        check("t4b_frame_done_after", fd_cnt, 1);
        check("t4b_wrst_pulses", wrst_pulses, 2);
        q.delete();

        // T5: reset while a pixel byte is stalled.
        clear_counts();
        pulse_start(1'b0);
        vs_pulse(20, 50);
        vsync = 1'b1; tick(20); vsync = 1'b0;
        wait_hs("t5_reach_px", 4, 200);
        rdy_mode = 2;
        begin
            int n = 0;
            while (!m_valid && n < 50) begin tick(1); n++; end
            check("t5_stalled_valid", m_valid, 1);
        end
        tick(3);
        reset_p = 1'b1;
        tick(1);
        check_reset_outputs("t5_reset");
        reset_p = 1'b0;
        rdy_mode = 0;
        q.delete();
        clear_counts();
        pulse_start(1'b0);
        vs_pulse(20, 50);
        vs_pulse(20, 300);
        wait_idle("t5_idle", 400);
        check("t5_bytes", hs_cnt, N1 + 2);
        check("t5_frame_done", fd_cnt, 1);

        // T6: start pulses while busy are ignored.
        clear_counts();
        pulse_start(1'b0);
        tick(5);
        pulse_start(1'b0);
        vs_pulse(20, 50);
        pulse_start(1'b0);
        vsync = 1'b1; tick(20); vsync = 1'b0;
        tick(30);
        pulse_start(1'b0);
        wait_idle("t6_idle", 400);
        vs_pulse(20, 50);
        vs_pulse(20, 50);
        check("t6_busy", busy, 0);
        check("t6_wrst_pulses", wrst_pulses, 1);
        check("t6_frame_done", fd_cnt, 1);
        check("t6_bytes", hs_cnt, N1 + 2);

        // T6b: RCLK_HALF=3 instance, no header, two bytes.
        n_r3 = 0; hs3 = 0; fd3 = 0;
        start3 = 1'b1; tick(2); start3 = 1'b0;
        vs_pulse(20, 50);
        vs_pulse(20, 100);
        begin
            int n = 0;
            while (busy3 && n < 200) begin tick(1); n++; end
            check("t6b_idle", busy3, 0);
        end
        check("t6b_bytes", hs3, 2);
        check("t6b_frame_done", fd3, 1);
        check("t6b_rclk_rises", n_r3, 4);
        check("t6b_rrst_rclk_period", rise_t3[1] - rise_t3[0], 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
